fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of 2, >=2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rom_req  output  1  fetch request, registered.
REQ-007 SHALL have port rom_addr  output  XLEN  fetch address, registered.
REQ-008 SHALL have port rom_ack  input  1  rom_data valid for the outstanding request this cycle.
REQ-009 SHALL have port rom_data  input  32  instruction word.
REQ-010 SHALL have port redirect  input  1  branch/jump flush.
REQ-011 SHALL have port redirect_pc  input  XLEN  new fetch address.
REQ-012 SHALL have port id_ready  input  1  decode stage accepts head.
REQ-013 SHALL have port id_valid  output  1  head entry valid.
REQ-014 SHALL have port id_pc  output  XLEN  PC of head entry.
REQ-015 SHALL have port id_is  output  32  instruction of head entry.
REQ-016 SHALL have port count  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-017 SHALL implement a DEPTH-entry circular FIFO of {pc, instruction}; head/tail pointers wrap modulo DEPTH.
REQ-018 SHALL pop the head when id_valid && id_ready; id_pc/id_is stable while id_valid && !id_ready.
REQ-019 SHALL provide no bypass: an entry pushed on an ack cycle is visible on id_valid the next cycle.
REQ-020 SHALL implement FSM IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding request invalidated by redirect).
REQ-021 SHALL keep at most one request outstanding; rom_req and rom_addr held constant until the cycle rom_ack=1.
REQ-022 IDLE: if post-update count < DEPTH and no redirect, next cycle rom_req=1, rom_addr=fetch_pc, go WAIT; else stay IDLE, rom_req=0.
REQ-023 WAIT, rom_ack=1, no redirect: push {rom_addr, rom_data}; fetch_pc=rom_addr+4; if post-update count < DEPTH, issue next address back-to-back (rom_req stays 1), stay WAIT; else rom_req=0, go IDLE.
REQ-024 Post-update count SHALL account for same-cycle push and pop.
REQ-025 redirect=1 SHALL flush all entries (count=0, id_valid=0 next cycle) and set fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
REQ-026 redirect in WAIT without rom_ack: go DROP; rom_req held with old rom_addr until ack; that ack's data discarded; then issue fetch_pc next cycle.
REQ-027 redirect in WAIT with rom_ack, or in IDLE: ack data discarded; next cycle rom_req=1, rom_addr=redirected PC, WAIT.
REQ-028 redirect in DROP: update fetch_pc only; remain DROP.
REQ-029 redirect SHALL take priority over push and pop; a same-cycle pop still counts as consumed.
REQ-030 PC increment SHALL wrap modulo 2^XLEN (0xFFFFFFFC+4 -> 0x00000000 for XLEN=32).
REQ-031 rom_ack while rom_req=0 SHALL be ignored.

Reset
REQ-032 On rst=0, asynchronously: count=0, id_valid=0, id_pc=0, id_is=0, rom_req=0, rom_addr=RESET_PC, fetch_pc=RESET_PC, pointers=0, FSM=IDLE.
REQ-033 First rising edge with rst=1 SHALL raise rom_req with rom_addr=RESET_PC.
REQ-034 Reset mid-operation SHALL discard outstanding request and all entries.

Verification
REQ-035 Reset release, ack 1 cycle after each req, id_ready=1: rom_addr sequence 0x0,0x4,0x8,...; id_pc follows one cycle after each ack.
REQ-036 DEPTH=4, id_ready=0, zero-wait ack: exactly 4 pushes, count=4, rom_req=0; one pop -> rom_req re-asserts next cycle with next address.
REQ-037 Redirect to 0x103 while WAIT at 0x40, ack 3 cycles later: 0x40 data dropped, next rom_addr=0x100, queue empty, no 0x40 entry at id.
REQ-038 Redirect coinciding with ack and pop, count=2: count=0, id_valid=0 next cycle, rom_addr=redirect target.
REQ-039 redirect_pc=0xFFFFFFFC: fetches 0xFFFFFFFC then 0x00000000.
REQ-040 rst asserted with 3 entries and outstanding request: all outputs at reset values immediately, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's ROM-side, redirect and decode-side signals.
// master is the queue itself; slave is its environment (ROM, branch unit, decode).
interface fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  logic                         rom_req;
  logic [XLEN-1:0]              rom_addr;
  logic                         rom_ack;
  logic [31:0]                  rom_data;
  logic                         redirect;
  logic [XLEN-1:0]              redirect_pc;
  logic                         id_ready;
  logic                         id_valid;
  logic [XLEN-1:0]              id_pc;
  logic [31:0]                  id_is;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output rom_req, rom_addr, id_valid, id_pc, id_is, count,
    input  rom_ack, rom_data, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  rom_req, rom_addr, id_valid, id_pc, id_is, count,
    output rom_ack, rom_data, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding ROM request at a time feeding a
// DEPTH-entry {pc, instruction} FIFO, with redirect flush and in-flight drop.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e          r_state, w_state_d;
  logic            r_req, w_req_d;
  logic [XLEN-1:0] r_addr, w_addr_d;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_d;
  logic [PW-1:0]   r_head, w_head_d;
  logic [PW-1:0]   r_tail, w_tail_d;
  logic [CW-1:0]   r_count, w_count_d;
  logic [XLEN-1:0] r_pc_mem [DEPTH];
  logic [31:0]     r_is_mem [DEPTH];

  logic            w_ack, w_pop, w_push, w_room;
  logic [XLEN-1:0] w_redir_pc, w_next_pc;
  logic            unused_redir_lsb;

  // An ack without a live request is meaningless and is dropped here.
  assign w_ack      = bus.rom_ack & r_req;
  assign w_pop      = (r_count != '0) & bus.id_ready;
  assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign w_next_pc  = r_addr + XLEN'(3'd4);
  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  always_comb begin
    w_state_d    = r_state;
    w_req_d      = r_req;
    w_addr_d     = r_addr;
    w_fetch_pc_d = r_fetch_pc;
    w_head_d     = r_head;
    w_tail_d     = r_tail;
    w_count_d    = r_count;
    w_push       = 1'b0;

    if (bus.redirect) begin
      w_head_d     = '0;
      w_tail_d     = '0;
      w_count_d    = '0;
      w_fetch_pc_d = w_redir_pc;
    end else begin
      w_push    = w_ack && (r_state == StWait);
      w_count_d = r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        w_tail_d     = r_tail + PW'(1);
        w_fetch_pc_d = w_next_pc;
      end
      if (w_pop) w_head_d = r_head + PW'(1);
    end

    w_room = (w_count_d < CW'(DEPTH));

    unique case (r_state)
      StIdle: begin
        if (bus.redirect) begin
          w_req_d   = 1'b1;
          w_addr_d  = w_redir_pc;
          w_state_d = StWait;
        end else if (w_room) begin
          w_req_d   = 1'b1;
          w_addr_d  = r_fetch_pc;
          w_state_d = StWait;
        end else begin
          w_req_d   = 1'b0;
        end
      end
      StWait: begin
        if (bus.redirect) begin
          if (w_ack) begin
            w_req_d  = 1'b1;
            w_addr_d = w_redir_pc;
          end else begin
            w_state_d = StDrop;
          end
        end else if (w_ack) begin
          if (w_room) begin
            w_req_d  = 1'b1;
            w_addr_d = w_next_pc;
          end else begin
            w_req_d   = 1'b0;
            w_state_d = StIdle;
          end
        end
      end
      StDrop: begin
        // The stale request stays on the bus until it completes; its data is discarded.
        if (w_ack) begin
          w_req_d   = 1'b1;
          w_addr_d  = bus.redirect ? w_redir_pc : r_fetch_pc;
          w_state_d = StWait;
        end
      end
      default: begin
        w_req_d   = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_req      <= w_req_d;
      r_addr     <= w_addr_d;
      r_fetch_pc <= w_fetch_pc_d;
      r_head     <= w_head_d;
      r_tail     <= w_tail_d;
      r_count    <= w_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i] <= '0;
        r_is_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_tail] <= r_addr;
      r_is_mem[r_tail] <= bus.rom_data;
    end
  end

  assign bus.rom_req  = r_req;
  assign bus.rom_addr = r_addr;
  assign bus.id_valid = (r_count != '0);
  assign bus.id_pc    = r_pc_mem[r_head];
  assign bus.id_is    = r_is_mem[r_head];
  assign bus.count    = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a ROM responder with ack budget/latency, and a
// scoreboard monitor comparing every decode-side pop against queued expectations.
module tb_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] is;
  } exp_t;

  logic clk;
  logic rst;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) fq ();

  fetch_queue #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fq)
  );

  exp_t        exp_q[$];
  logic [31:0] ack_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_budget = 0;
  int          ack_lat    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.is = instr_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    #3;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b0;
    ack_budget     = 0;
    fq.redirect    = 1'b0;
    fq.id_ready    = 1'b0;
    exp_q.delete();
    ack_log.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ROM model: acks after ack_lat waiting cycles, while budget remains.
  initial begin : responder
    int pend;
    pend        = 0;
    fq.rom_ack  = 1'b0;
    fq.rom_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst && fq.rom_req && ack_budget > 0) begin
        if (pend >= ack_lat) begin
          fq.rom_ack  = 1'b1;
          fq.rom_data = instr_of(fq.rom_addr);
          ack_log.push_back(fq.rom_addr);
          ack_budget--;
          pend = 0;
        end else begin
          fq.rom_ack = 1'b0;
          pend++;
        end
      end else begin
        fq.rom_ack = 1'b0;
        pend       = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (fq.id_valid && fq.id_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop_pc", fq.id_pc, 32'hDEAD_DEAD);
          end else begin
            e = exp_q.pop_front();
            check("pop_pc", fq.id_pc, e.pc);
            check("pop_is", fq.id_is, e.is);
          end
        end
        if (fq.redirect) exp_q.delete();
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst            = 1'b1;
    fq.redirect    = 1'b0;
    fq.redirect_pc = '0;
    fq.id_ready    = 1'b0;
    #2;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    #3;
    check("rst_rom_req",  32'(fq.rom_req),  32'd0);
    check("rst_rom_addr", fq.rom_addr,      32'h0);
    check("rst_id_valid", 32'(fq.id_valid), 32'd0);
    check("rst_count",    32'(fq.count),    32'd0);
    check("rst_id_pc",    fq.id_pc,         32'h0);
    check("rst_id_is",    fq.id_is,         32'h0);

    // Sequential fetch, 1-cycle ack latency, decode always ready
    @(negedge clk);
    rst         = 1'b1;
    ack_lat     = 1;
    ack_budget  = 8;
    fq.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_push(32'(i * 4));
    @(negedge clk);
    #3;
    check("first_req",  32'(fq.rom_req), 32'd1);
    check("first_addr", fq.rom_addr,     32'h0);
    wait_drain("seq_drain");
    check("seq_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size(); i++) check("seq_addr", ack_log[i], 32'(i * 4));

    // Fill to DEPTH with decode stalled, then one pop restarts fetch
    do_reset();
    ack_lat    = 0;
    ack_budget = 100;
    repeat (8) @(negedge clk);
    #3;
    check("full_count",    32'(fq.count),       32'd4);
    check("full_rom_req",  32'(fq.rom_req),     32'd0);
    check("full_id_valid", 32'(fq.id_valid),    32'd1);
    check("full_acks",     32'(ack_log.size()), 32'd4);
    @(negedge clk);
    exp_push(32'h0);
    fq.id_ready = 1'b1;
    @(negedge clk);
    fq.id_ready = 1'b0;
    #3;
    check("refill_req",  32'(fq.rom_req), 32'd1);
    check("refill_addr", fq.rom_addr,     32'h10);
    @(negedge clk);
    ack_budget = 0;
    #3;
    check("refull_count", 32'(fq.count),   32'd4);
    check("refull_req",   32'(fq.rom_req), 32'd0);
    @(negedge clk);
    exp_push(32'h4);
    exp_push(32'h8);
    exp_push(32'hC);
    exp_push(32'h10);
    fq.id_ready = 1'b1;
    wait_drain("full_drain");
    check("drained_count", 32'(fq.count),    32'd0);
    check("drained_valid", 32'(fq.id_valid), 32'd0);
    check("drained_addr",  fq.rom_addr,      32'h14);

    // Redirect while waiting: in-flight 0x40 is dropped, fetch resumes at 0x100
    do_reset();
    ack_lat     = 0;
    fq.id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h40;
    ack_budget     = 1;
    @(negedge clk);
    fq.redirect = 1'b0;
    #3;
    check("redir_ack_addr",  fq.rom_addr,   32'h40);
    check("redir_ack_req",   32'(fq.rom_req), 32'd1);
    check("redir_ack_count", 32'(fq.count),   32'd0);
    @(negedge clk);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h103;
    @(negedge clk);
    fq.redirect = 1'b0;
    #3;
    check("drop_hold_addr", fq.rom_addr,      32'h40);
    check("drop_hold_req",  32'(fq.rom_req),  32'd1);
    check("drop_valid",     32'(fq.id_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    ack_budget = 4;
    exp_push(32'h100);
    exp_push(32'h104);
    exp_push(32'h108);
    wait_drain("drop_drain");
    check("drop_next_addr", fq.rom_addr, 32'h10C);

    // Redirect coinciding with ack and pop while two entries are held
    do_reset();
    ack_lat    = 0;
    ack_budget = 2;
    repeat (6) @(negedge clk);
    #3;
    check("pre_flush_count", 32'(fq.count), 32'd2);
    check("pre_flush_addr",  fq.rom_addr,   32'h8);
    @(negedge clk);
    exp_push(32'h0);
    fq.id_ready    = 1'b1;
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h200;
    ack_budget     = 1;
    @(negedge clk);
    fq.redirect = 1'b0;
    fq.id_ready = 1'b0;
    ack_budget  = 0;
    #3;
    check("flush_count", 32'(fq.count),    32'd0);
    check("flush_valid", 32'(fq.id_valid), 32'd0);
    check("flush_req",   32'(fq.rom_req),  32'd1);
    check("flush_addr",  fq.rom_addr,      32'h200);

    // Address wrap: 0xFFFFFFFC then 0x0 (unaligned target forced to word boundary)
    do_reset();
    ack_lat     = 0;
    fq.id_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'hFFFF_FFFF;
    ack_budget     = 1;
    @(negedge clk);
    fq.redirect = 1'b0;
    ack_budget  = 3;
    exp_push(32'hFFFF_FFFC);
    exp_push(32'h0);
    exp_push(32'h4);
    #3;
    check("wrap_first_addr", fq.rom_addr, 32'hFFFF_FFFC);
    wait_drain("wrap_drain");
    check("wrap_next_addr", fq.rom_addr, 32'h8);

    // Asynchronous reset with three entries and a request outstanding
    do_reset();
    ack_lat    = 0;
    ack_budget = 3;
    repeat (6) @(negedge clk);
    #3;
    check("pre_rst_count", 32'(fq.count),   32'd3);
    check("pre_rst_req",   32'(fq.rom_req), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_req",   32'(fq.rom_req),  32'd0);
    check("mid_rst_addr",  fq.rom_addr,      32'h0);
    check("mid_rst_valid", 32'(fq.id_valid), 32'd0);
    check("mid_rst_count", 32'(fq.count),    32'd0);
    check("mid_rst_pc",    fq.id_pc,         32'h0);
    check("mid_rst_is",    fq.id_is,         32'h0);
    ack_log.delete();
    @(negedge clk);
    rst         = 1'b1;
    ack_budget  = 3;
    fq.id_ready = 1'b1;
    exp_push(32'h0);
    exp_push(32'h4);
    exp_push(32'h8);
    wait_drain("restart_drain");
    check("restart_addr", fq.rom_addr, 32'hC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
